// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: streams W[0..63] from a 16-word sliding window.
// Define SHA256_KROM_EN to add the K[t] constant ROM and the k_t output.
module sha256_msg_schedule (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    output logic         w_valid,
    input  logic         w_ready,
    output logic [31:0]  w_t,
    output logic [5:0]   t_idx,
    output logic         w_last
`ifdef SHA256_KROM_EN
    ,
    output logic [31:0]  k_t
`endif
);

    typedef enum logic {IDLE, RUN} state_e;

    state_e      state_q, state_d;
    logic [31:0] win_q [16];
    logic [31:0] win_d [16];
    logic [5:0]  t_q, t_d;
    logic [31:0] w_new;

    function automatic logic [31:0] rotr(
        input logic [31:0] x,
        input int          n
    );
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // win[k] holds W[t+k]; the new tail word is W[t+16]
    assign w_new = sig1(win_q[14]) + win_q[9]
                 + sig0(win_q[1]) + win_q[0];

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        t_d     = t_q;
        unique case (state_q)
            IDLE: begin
                if (blk_valid) begin
                    for (int i = 0; i < 16; i++)
                        win_d[i] = blk_data[511 - 32*i -: 32];
                    t_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (w_ready) begin
                    for (int i = 0; i < 15; i++)
                        win_d[i] = win_q[i + 1];
                    win_d[15] = w_new;
                    t_d       = t_q + 6'd1;
                    if (t_q == 6'd63)
                        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            t_q     <= '0;
            for (int i = 0; i < 16; i++)
                win_q[i] <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            for (int i = 0; i < 16; i++)
                win_q[i] <= win_d[i];
        end
    end

    assign blk_ready = (state_q == IDLE);
    assign w_valid   = (state_q == RUN);
    assign w_t       = win_q[0];
    assign t_idx     = t_q;
    assign w_last    = w_valid && (t_q == 6'd63);

`ifdef SHA256_KROM_EN
    localparam logic [31:0] KROM [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // indexed by the registered t so k_t always pairs with w_t
    assign k_t = KROM[t_q];
`endif

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Self-checking bench for sha256_msg_schedule (both KROM build options).
// Reference W[] is expanded from the FIPS recurrence over a full array.
module tb_sha256_msg_schedule;

    logic         clk;
    logic         rst_n;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         w_valid;
    logic         w_ready;
    logic [31:0]  w_t;
    logic [5:0]   t_idx;
    logic         w_last;
`ifdef SHA256_KROM_EN
    logic [31:0]  k_t;
`endif

    sha256_msg_schedule dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_t       (w_t),
        .t_idx     (t_idx),
        .w_last    (w_last)
`ifdef SHA256_KROM_EN
        ,
        .k_t       (k_t)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          t;
        logic [31:0] w;
    } vec_t;

    int          vec;
    int          bad;
    int          et;
    logic [31:0] wm  [64];
    logic [31:0] wm1 [64];
    logic [31:0] wm2 [64];
    logic [31:0] cap [64];
    vec_t        tbl [4];

    function automatic logic [31:0] s0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] s1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (et=%0d)", nm, act, exp, et);
        end
    endtask

    task automatic model(input logic [511:0] b);
        for (int i = 0; i < 16; i++)
            wm[i] = b[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++)
            wm[i] = s1(wm[i-2]) + wm[i-7] + s0(wm[i-15]) + wm[i-16];
    endtask

    task automatic idle_chk(input string nm);
        chk({nm, "_blk_ready"}, 32'(blk_ready), 1);
        chk({nm, "_w_valid"}, 32'(w_valid), 0);
        chk({nm, "_w_last"}, 32'(w_last), 0);
    endtask

    task automatic load(input logic [511:0] b);
        idle_chk("load");
        model(b);
        et        = 0;
        blk_data  = b;
        blk_valid = 1'b1;
        @(negedge clk);
        blk_valid = 1'b0;
    endtask

    // called at a negedge; runs until t_to beats of the block are accepted
    task automatic stream(input int t_to, input int bp);
        int budget = 2000;
        while (et < t_to && budget > 0) begin
            budget--;
            chk("w_valid", 32'(w_valid), 1);
            chk("blk_ready", 32'(blk_ready), 0);
            chk("t_idx", 32'(t_idx), 32'(et));
            chk("w_t", w_t, wm[et]);
            chk("w_last", 32'(w_last), 32'(et == 63));
`ifdef SHA256_KROM_EN
            if (et == 0)  chk("k_t0", k_t, 32'h428a2f98);
            if (et == 1)  chk("k_t1", k_t, 32'h71374491);
            if (et == 63) chk("k_t63", k_t, 32'hc67178f2);
`endif
            w_ready = ($urandom_range(99) >= bp);
            if (w_ready && w_valid) et++;
            @(negedge clk);
        end
        if (budget == 0) begin
            vec++;
            bad++;
            $display("FAIL stream_timeout: got et=%0d want %0d", et, t_to);
        end
    endtask

    function automatic logic [511:0] rnd_blk();
        logic [511:0] b;
        for (int i = 0; i < 16; i++)
            b[32*i +: 32] = $urandom();
        return b;
    endfunction

    initial begin
        logic [511:0] abc;
        logic [511:0] b1;
        logic [511:0] b2;
        int beats, lasts, last_t, nmis, budget;

        vec       = 0;
        bad       = 0;
        et        = 0;
        rst_n     = 1'b0;
        blk_valid = 1'b0;
        blk_data  = '0;
        w_ready   = 1'b0;

        #2;
        chk("rst_blk_ready", 32'(blk_ready), 1);
        chk("rst_w_valid", 32'(w_valid), 0);
        chk("rst_w_last", 32'(w_last), 0);
        chk("rst_t_idx", 32'(t_idx), 0);
        chk("rst_w_t", w_t, 0);
`ifdef SHA256_KROM_EN
        chk("rst_k_t", k_t, 32'h428a2f98);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // "abc" block, full rate, captured then compared via table
        tbl[0] = '{0,  32'h61626380};
        tbl[1] = '{15, 32'h00000018};
        tbl[2] = '{16, 32'h61626380};
        tbl[3] = '{17, 32'h000F0000};
        abc          = '0;
        abc[511:480] = 32'h61626380;
        abc[31:0]    = 32'h00000018;
        load(abc);
        beats  = 0;
        lasts  = 0;
        last_t = -1;
        budget = 200;
        w_ready = 1'b1;
        while (beats < 64 && budget > 0) begin
            budget--;
            if (w_valid) begin
                cap[t_idx] = w_t;
                if (w_last) begin
                    lasts++;
                    last_t = int'(t_idx);
                end
                beats++;
            end
            @(negedge clk);
        end
        chk("abc_beats", 32'(beats), 64);
        chk("abc_last_count", 32'(lasts), 1);
        chk("abc_last_t", 32'(last_t), 63);
        for (int i = 0; i < 4; i++)
            chk($sformatf("abc_W%0d", tbl[i].t), cap[tbl[i].t], tbl[i].w);
        nmis = 0;
        for (int i = 0; i < 64; i++)
            if (cap[i] !== wm[i]) nmis++;
        chk("abc_model_words", 32'(nmis), 0);
        idle_chk("abc_end");

        // backpressure at t=16
        load(abc);
        stream(16, 0);
        for (int i = 0; i < 5; i++) begin
            chk("bp_w_t", w_t, 32'h61626380);
            chk("bp_t_idx", 32'(t_idx), 16);
            chk("bp_w_valid", 32'(w_valid), 1);
            w_ready = 1'b0;
            @(negedge clk);
        end
        stream(17, 0);
        chk("bp_W17", w_t, 32'h000F0000);
        stream(64, 30);
        idle_chk("bp_end");

        // blk_valid with other data during RUN is ignored
        b1 = rnd_blk();
        load(b1);
        stream(10, 20);
        blk_data  = ~b1;
        blk_valid = 1'b1;
        stream(13, 0);
        blk_valid = 1'b0;
        stream(64, 20);
        idle_chk("busy_end");

        // reset mid-block at t=30
        load(rnd_blk());
        stream(30, 0);
        rst_n = 1'b0;
        #1;
        chk("mrst_w_valid", 32'(w_valid), 0);
        chk("mrst_blk_ready", 32'(blk_ready), 1);
        chk("mrst_t_idx", 32'(t_idx), 0);
        chk("mrst_w_t", w_t, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        load(rnd_blk());
        stream(64, 25);
        idle_chk("mrst_end");

        // back-to-back blocks with blk_valid held high
        b1 = rnd_blk();
        b2 = rnd_blk();
        model(b1);
        wm1 = wm;
        model(b2);
        wm2 = wm;
        blk_data  = b1;
        blk_valid = 1'b1;
        w_ready   = 1'b1;
        for (int k = 1; k <= 66; k++) begin
            @(negedge clk);
            if (k <= 64) begin
                chk("b2b_valid", 32'(w_valid), 1);
                chk("b2b_t_idx", 32'(t_idx), 32'(k - 1));
                chk("b2b_w_t", w_t, wm1[k-1]);
                if (k == 64) blk_data = b2;
            end else if (k == 65) begin
                chk("b2b_gap_ready", 32'(blk_ready), 1);
                chk("b2b_gap_valid", 32'(w_valid), 0);
            end else begin
                chk("b2b2_valid", 32'(w_valid), 1);
                chk("b2b2_t_idx", 32'(t_idx), 0);
                chk("b2b2_W0", w_t, wm2[0]);
            end
        end
        blk_valid = 1'b0;
        wm = wm2;
        et = 0;
        stream(64, 0);
        idle_chk("b2b_end");

        // randomized blocks under random backpressure
        for (int n = 0; n < 4; n++) begin
            load(rnd_blk());
            stream(64, 40);
            idle_chk("rnd_end");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule
